// File: rtl/key_debounce_repeat.sv
// Per-key synchroniser, debouncer and press/release strobe generator with optional auto-repeat.
// Optional feature macro: KEY_AUTO_REPEAT_EN (builds the repeat FSM; otherwise KEY_PULSE == KEY_PRESS).
module key_debounce_repeat #(
  parameter int N_KEYS       = 5,
  parameter int DEBOUNCE_CYC = 20000,
  parameter int HOLD_CYC     = 500000,
  parameter int REPEAT_CYC   = 100000
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] KEY_LEVEL,
  output logic [N_KEYS-1:0] KEY_PRESS,
  output logic [N_KEYS-1:0] KEY_RELEASE,
  output logic [N_KEYS-1:0] KEY_PULSE
);

  localparam int DW = $clog2(DEBOUNCE_CYC);

  logic [N_KEYS-1:0] s1_q, s2_q;
  logic [N_KEYS-1:0] level_q, press_q, release_q, pulse_q;
  logic [DW-1:0]     cnt_q [N_KEYS];
  logic [N_KEYS-1:0] accept_d, press_d, release_d;

  // A level change is accepted on the edge where the counter has seen DEBOUNCE_CYC stable samples.
  always_comb begin
    accept_d  = '0;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      accept_d[i]  = (s2_q[i] != level_q[i]) && (cnt_q[i] == DW'(DEBOUNCE_CYC - 1));
      press_d[i]   = accept_d[i] & s2_q[i];
      release_d[i] = accept_d[i] & ~s2_q[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      s1_q      <= '0;
      s2_q      <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N_KEYS; i++) cnt_q[i] <= '0;
    end else begin
      s1_q      <= KEY;
      s2_q      <= s1_q;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < N_KEYS; i++) begin
        if (s2_q[i] == level_q[i]) begin
          cnt_q[i] <= '0;
        end else if (accept_d[i]) begin
          level_q[i] <= s2_q[i];
          cnt_q[i]   <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + DW'(1);
        end
      end
    end
  end

`ifdef KEY_AUTO_REPEAT_EN
  localparam int RMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int RW   = $clog2(RMAX);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  rep_state_e    state_q [N_KEYS];
  logic [RW-1:0] rcnt_q  [N_KEYS];

  // Release wins over a repeat pulse landing on the same edge.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      pulse_q <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= ST_IDLE;
        rcnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        pulse_q[i] <= press_d[i];
        if (release_d[i]) begin
          state_q[i] <= ST_IDLE;
          rcnt_q[i]  <= '0;
        end else begin
          case (state_q[i])
            ST_IDLE: begin
              if (press_d[i]) begin
                state_q[i] <= ST_HELD;
                rcnt_q[i]  <= '0;
              end
            end
            ST_HELD: begin
              if (rcnt_q[i] == RW'(HOLD_CYC - 1)) begin
                pulse_q[i] <= 1'b1;
                rcnt_q[i]  <= '0;
                state_q[i] <= ST_REPEAT;
              end else begin
                rcnt_q[i] <= rcnt_q[i] + RW'(1);
              end
            end
            ST_REPEAT: begin
              if (rcnt_q[i] == RW'(REPEAT_CYC - 1)) begin
                pulse_q[i] <= 1'b1;
                rcnt_q[i]  <= '0;
              end else begin
                rcnt_q[i] <= rcnt_q[i] + RW'(1);
              end
            end
            default: begin
              state_q[i] <= ST_IDLE;
              rcnt_q[i]  <= '0;
            end
          endcase
        end
      end
    end
  end
`else
  always_ff @(posedge CLK) begin
    if (!RESETN) pulse_q <= '0;
    else         pulse_q <= press_d;
  end
`endif

  assign KEY_LEVEL   = level_q;
  assign KEY_PRESS   = press_q;
  assign KEY_RELEASE = release_q;
  assign KEY_PULSE   = pulse_q;

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Directed bench for key_debounce_repeat: DEBOUNCE_CYC=8, HOLD_CYC=20, REPEAT_CYC=5.
// Expected cycles are hand-derived; k counts rising edges after the last input change.
module tb_key_debounce_repeat;

  localparam int NK   = 5;
  localparam int DB   = 8;
  localparam int HOLD = 20;
  localparam int REP  = 5;
`ifdef KEY_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic          CLK;
  logic          RESETN;
  logic [NK-1:0] KEY;
  logic [NK-1:0] KEY_LEVEL, KEY_PRESS, KEY_RELEASE, KEY_PULSE;

  int n_tests = 0;
  int n_fail  = 0;

  key_debounce_repeat #(
    .N_KEYS       (NK),
    .DEBOUNCE_CYC (DB),
    .HOLD_CYC     (HOLD),
    .REPEAT_CYC   (REP)
  ) dut (
    .CLK         (CLK),
    .RESETN      (RESETN),
    .KEY         (KEY),
    .KEY_LEVEL   (KEY_LEVEL),
    .KEY_PRESS   (KEY_PRESS),
    .KEY_RELEASE (KEY_RELEASE),
    .KEY_PULSE   (KEY_PULSE)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check($sformatf("%s_level", tag),   KEY_LEVEL,   '0);
    check($sformatf("%s_press", tag),   KEY_PRESS,   '0);
    check($sformatf("%s_release", tag), KEY_RELEASE, '0);
    check($sformatf("%s_pulse", tag),   KEY_PULSE,   '0);
  endtask

  // Runs n edges; the level change is accepted at edge acc_k. Repeat pulses are expected at
  // rep_first, rep_first+REP, ... while below rep_stop (rep_first=0: none).
  task automatic run_phase(input string tag, input int n,
                           input logic [NK-1:0] lvl0, input logic [NK-1:0] lvl1,
                           input int acc_k, input logic [NK-1:0] mask, input bit rising,
                           input int rep_first, input int rep_stop);
    logic [NK-1:0] e_lvl, e_press, e_rel, e_pulse;
    for (int k = 1; k <= n; k++) begin
      step();
      e_lvl   = (k >= acc_k) ? lvl1 : lvl0;
      e_press = (rising && k == acc_k) ? mask : '0;
      e_rel   = (!rising && k == acc_k) ? mask : '0;
      e_pulse = e_press;
      if (AR && rep_first > 0 && k >= rep_first && k < rep_stop && ((k - rep_first) % REP) == 0)
        e_pulse = e_pulse | mask;
      check($sformatf("%s_level_k%0d", tag, k),   KEY_LEVEL,   e_lvl);
      check($sformatf("%s_press_k%0d", tag, k),   KEY_PRESS,   e_press);
      check($sformatf("%s_release_k%0d", tag, k), KEY_RELEASE, e_rel);
      check($sformatf("%s_pulse_k%0d", tag, k),   KEY_PULSE,   e_pulse);
    end
  endtask

  // driver sequence
  initial begin
    RESETN = 1'b0;
    KEY    = '1;
    step();
    check_all_zero("rst0");
    step();
    check_all_zero("rst1");
    RESETN = 1'b1;

    // all keys held through reset: accepted 10 edges after release of reset
    run_phase("s1_on", 12, 5'h00, 5'h1F, 10, 5'h1F, 1'b1, 0, 0);
    KEY = '0;
    run_phase("s1_off", 12, 5'h1F, 5'h00, 10, 5'h1F, 1'b0, 0, 0);

    // 7-cycle glitch is rejected
    KEY = 5'b00001;
    for (int k = 1; k <= 19; k++) begin
      step();
      check($sformatf("s2_level_k%0d", k), KEY_LEVEL, '0);
      check($sformatf("s2_press_k%0d", k), KEY_PRESS, '0);
      check($sformatf("s2_pulse_k%0d", k), KEY_PULSE, '0);
      if (k == 7) KEY = '0;
    end

    // press and hold: press at 10, repeats at 30, 35, ... 60
    KEY = 5'b00100;
    run_phase("s3_hold", 60, 5'h00, 5'h04, 10, 5'h04, 1'b1, 30, 1000);
    // release at t+60: repeat at t+65 still fires, the one due at t+70 is cut by the release
    KEY = '0;
    run_phase("s5_rel", 15, 5'h04, 5'h00, 10, 5'h04, 1'b0, 5, 10);

    // two keys rising together
    KEY = 5'b10001;
    run_phase("s6_on", 12, 5'h00, 5'h11, 10, 5'h11, 1'b1, 0, 0);
    KEY = '0;
    run_phase("s6_off", 12, 5'h11, 5'h00, 10, 5'h11, 1'b0, 0, 0);

    // reset in the middle of auto-repeat with the key still held
    KEY = 5'b00100;
    run_phase("s7_pre", 31, 5'h00, 5'h04, 10, 5'h04, 1'b1, 30, 1000);
    RESETN = 1'b0;
    step();
    check_all_zero("s7_rst");
    RESETN = 1'b1;
    run_phase("s7_re", 12, 5'h00, 5'h04, 10, 5'h04, 1'b1, 0, 0);
    KEY = '0;
    run_phase("s7_off", 12, 5'h04, 5'h00, 10, 5'h04, 1'b0, 0, 0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
